// File: rtl/crc_stream_engine_if.sv
// Stream and control bundle for the CRC engine: configuration, word stream
// handshake and result. The master drives the message; the engine is the slave.
interface crc_stream_engine_if #(
    parameter int DATA_WIDTH = 32
);
    localparam int NB = DATA_WIDTH / 8;
    localparam int CW = $clog2(NB) + 1;

    logic                  start;
    logic                  abort;
    logic [1:0]            cfg_width;
    logic [31:0]           cfg_poly;
    logic [31:0]           cfg_init;
    logic [31:0]           cfg_xorout;
    logic                  cfg_refin;
    logic                  cfg_refout;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_last;
    logic [CW-1:0]         in_bytes;
    logic                  busy;
    logic                  crc_valid;
    logic [31:0]           crc_out;

    modport master (
        output start, abort, cfg_width, cfg_poly, cfg_init, cfg_xorout,
        output cfg_refin, cfg_refout, in_valid, in_data, in_last, in_bytes,
        input  in_ready, busy, crc_valid, crc_out
    );

    modport slave (
        input  start, abort, cfg_width, cfg_poly, cfg_init, cfg_xorout,
        input  cfg_refin, cfg_refout, in_valid, in_data, in_last, in_bytes,
        output in_ready, busy, crc_valid, crc_out
    );
endinterface

// File: rtl/crc_stream_engine.sv
// Streaming CRC engine: configurable width/poly/init/reflection/xorout,
// one byte folded per clock, one-cycle result strobe on completion.
module crc_stream_engine #(
    parameter int DATA_WIDTH = 32
) (
    input logic                clk,
    input logic                rst,
    crc_stream_engine_if.slave bus
);
    localparam int NB = DATA_WIDTH / 8;
    localparam int CW = $clog2(NB) + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FINAL = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            width_q, width_d;
    logic [31:0]           poly_q, poly_d;
    logic [31:0]           xorout_q, xorout_d;
    logic                  refin_q, refin_d;
    logic                  refout_q, refout_d;
    logic [31:0]           crc_q, crc_d;
    logic [DATA_WIDTH-1:0] buf_q, buf_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  last_q, last_d;
    logic [31:0]           crc_out_q, crc_out_d;
    logic                  crc_valid_q, crc_valid_d;
    logic                  ready_s;
    logic                  xfer_s;
    logic [CW-1:0]         tail_bytes_s;

    // Low-W-bit mask; the reserved width code behaves as CRC-32.
    function automatic logic [31:0] width_mask(input logic [1:0] w);
        logic [31:0] m;
        case (w)
            2'd0:    m = 32'h0000_00FF;
            2'd1:    m = 32'h0000_FFFF;
            default: m = 32'hFFFF_FFFF;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] top_bit(input logic [1:0] w);
        logic [31:0] t;
        case (w)
            2'd0:    t = 32'h0000_0080;
            2'd1:    t = 32'h0000_8000;
            default: t = 32'h8000_0000;
        endcase
        return t;
    endfunction

    function automatic logic [7:0] bitrev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7 - i];
        return r;
    endfunction

    // Reverse the low W bits, result right-aligned.
    function automatic logic [31:0] bitrev_w(input logic [31:0] v, input logic [1:0] w);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = v[31 - i];
        case (w)
            2'd0:    r = r >> 5'd24;
            2'd1:    r = r >> 5'd16;
            default: r = r;
        endcase
        return r;
    endfunction

    // Fold one message byte into the W-bit register, MSB-first.
    function automatic logic [31:0] crc_fold(input logic [31:0] crc, input logic [7:0] data,
                                             input logic [1:0] w, input logic [31:0] poly,
                                             input logic refin);
        logic [7:0]  b;
        logic [31:0] r;
        b = refin ? bitrev8(data) : data;
        case (w)
            2'd0:    r = crc ^ {24'd0, b};
            2'd1:    r = crc ^ {16'd0, b, 8'd0};
            default: r = crc ^ {b, 24'd0};
        endcase
        for (int i = 0; i < 8; i++) begin
            if ((r & top_bit(w)) != 32'd0) r = (r << 1) ^ poly;
            else                           r = r << 1;
        end
        return r & width_mask(w);
    endfunction

    function automatic logic [31:0] crc_finalize(input logic [31:0] crc, input logic [1:0] w,
                                                 input logic refout, input logic [31:0] xorout);
        logic [31:0] r;
        r = refout ? bitrev_w(crc, w) : crc;
        return (r ^ xorout) & width_mask(w);
    endfunction

    // A new word is taken only when the byte buffer empties on this edge,
    // which keeps the fold pipeline full across word boundaries.
    assign ready_s      = (state_q == ST_RUN) && !last_q && (count_q <= CW'(1));
    assign xfer_s       = bus.in_valid && ready_s;
    assign tail_bytes_s = (bus.in_bytes > CW'(NB)) ? CW'(NB) : bus.in_bytes;

    assign bus.in_ready  = ready_s;
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.crc_valid = crc_valid_q;
    assign bus.crc_out   = crc_out_q;

    // Message FSM next state plus buffer, count and CRC register updates.
    always_comb begin
        state_d     = state_q;
        width_d     = width_q;
        poly_d      = poly_q;
        xorout_d    = xorout_q;
        refin_d     = refin_q;
        refout_d    = refout_q;
        crc_d       = crc_q;
        buf_d       = buf_q;
        count_d     = count_q;
        last_d      = last_q;
        crc_out_d   = crc_out_q;
        crc_valid_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    width_d  = bus.cfg_width;
                    poly_d   = bus.cfg_poly & width_mask(bus.cfg_width);
                    xorout_d = bus.cfg_xorout & width_mask(bus.cfg_width);
                    refin_d  = bus.cfg_refin;
                    refout_d = bus.cfg_refout;
                    crc_d    = bus.cfg_init & width_mask(bus.cfg_width);
                    count_d  = {CW{1'b0}};
                    last_d   = 1'b0;
                    state_d  = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (bus.abort) begin
                    count_d = {CW{1'b0}};
                    last_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    if (count_q != {CW{1'b0}}) begin
                        crc_d   = crc_fold(crc_q, buf_q[7:0], width_q, poly_q, refin_q);
                        buf_d   = buf_q >> 8;
                        count_d = count_q - CW'(1);
                    end else begin
                        crc_d = crc_q;
                    end
                    if (xfer_s) begin
                        if (bus.in_last && (bus.in_bytes == {CW{1'b0}})) begin
                            // Empty tail word: nothing to fold, finish now.
                            count_d = {CW{1'b0}};
                            state_d = ST_FINAL;
                        end else begin
                            buf_d   = bus.in_data;
                            count_d = bus.in_last ? tail_bytes_s : CW'(NB);
                            last_d  = bus.in_last;
                        end
                    end else if (last_q && (count_q == CW'(1))) begin
                        last_d  = 1'b0;
                        state_d = ST_FINAL;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_FINAL: begin
                if (bus.abort) begin
                    count_d = {CW{1'b0}};
                    last_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    crc_out_d   = crc_finalize(crc_q, width_q, refout_q, xorout_q);
                    crc_valid_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            width_q     <= 2'd0;
            poly_q      <= 32'd0;
            xorout_q    <= 32'd0;
            refin_q     <= 1'b0;
            refout_q    <= 1'b0;
            crc_q       <= 32'd0;
            buf_q       <= {DATA_WIDTH{1'b0}};
            count_q     <= {CW{1'b0}};
            last_q      <= 1'b0;
            crc_out_q   <= 32'd0;
            crc_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            width_q     <= width_d;
            poly_q      <= poly_d;
            xorout_q    <= xorout_d;
            refin_q     <= refin_d;
            refout_q    <= refout_d;
            crc_q       <= crc_d;
            buf_q       <= buf_d;
            count_q     <= count_d;
            last_q      <= last_d;
            crc_out_q   <= crc_out_d;
            crc_valid_q <= crc_valid_d;
        end
    end
endmodule

// File: tb/tb_crc_stream_engine.sv
// Testbench for crc_stream_engine: catalogue CRC vectors, timing corners,
// abort/reset sequences and randomized messages against a bit-serial model.
module tb_crc_stream_engine;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    int   start_edge, first_acc, last_acc, word_idx;
    int   nv, vcyc;
    bit   busy_bad;
    logic [31:0] got;
    logic [7:0]  msg_q[$];

    typedef struct {
        logic [1:0]  w;
        logic [31:0] poly;
        logic [31:0] init;
        logic [31:0] xo;
        logic        ri;
        logic        ro;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[5];

    crc_stream_engine_if #(.DATA_WIDTH(DW)) bus ();
    crc_stream_engine #(.DATA_WIDTH(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: message as a bit stream through a W-bit LFSR division.
    function automatic logic [31:0] ref_crc(input logic [1:0] w, input logic [31:0] poly,
                                           input logic [31:0] init, input logic [31:0] xo,
                                           input logic ri, input logic ro);
        int          W;
        logic [31:0] mask, crc, r;
        logic        m, fb;
        W    = (w == 2'd0) ? 8 : (w == 2'd1) ? 16 : 32;
        mask = (W == 32) ? 32'hFFFF_FFFF : ((32'h1 << W) - 32'h1);
        crc  = init & mask;
        foreach (msg_q[k]) begin
            for (int j = 0; j < 8; j++) begin
                m   = ri ? msg_q[k][j] : msg_q[k][7 - j];
                fb  = crc[W - 1] ^ m;
                crc = (crc << 1) & mask;
                if (fb) crc = crc ^ (poly & mask);
            end
        end
        r = crc;
        if (ro) begin
            r = 32'd0;
            for (int i = 0; i < W; i++) r[W - 1 - i] = crc[i];
        end
        return (r ^ xo) & mask;
    endfunction

    task automatic set_cfg(input logic [1:0] w, input logic [31:0] poly, input logic [31:0] init,
                           input logic [31:0] xo, input logic ri, input logic ro);
        bus.cfg_width  = w;
        bus.cfg_poly   = poly;
        bus.cfg_init   = init;
        bus.cfg_xorout = xo;
        bus.cfg_refin  = ri;
        bus.cfg_refout = ro;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        @(posedge clk); #1;
        start_edge = cyc;
        bus.start  = 1'b0;
        word_idx   = 0;
    endtask

    task automatic push_word(input logic [31:0] data, input logic last, input logic [2:0] nb,
                             input int gap_pct);
        bit done;
        for (int g = 0; g < 4 && gap_pct > 0 && $urandom_range(0, 99) < gap_pct; g++) begin
            bus.in_valid = 1'b0;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b1;
        bus.in_data  = data;
        bus.in_last  = last;
        bus.in_bytes = nb;
        done = 1'b0;
        for (int i = 0; i < 64 && !done; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                done = 1'b1;
                if (word_idx == 0) first_acc = cyc + 1;
                last_acc = cyc + 1;
                word_idx++;
            end
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        check("word_accepted", {31'd0, done}, 32'd1);
    endtask

    task automatic send_message(input int gap_pct, input bit zero_tail);
        int k;
        int len;
        k   = 0;
        len = msg_q.size();
        while (k < len) begin
            int          nb;
            logic [31:0] wd;
            bit          lst;
            nb = (len - k >= 4) ? 4 : len - k;
            wd = (gap_pct > 0) ? $urandom : 32'd0;
            for (int j = 0; j < nb; j++) wd[8 * j +: 8] = msg_q[k + j];
            k   = k + nb;
            lst = (k == len) && !zero_tail;
            push_word(wd, lst, 3'(nb), gap_pct);
        end
        if (len == 0 || zero_tail) push_word((gap_pct > 0) ? $urandom : 32'd0, 1'b1, 3'd0, gap_pct);
    endtask

    task automatic wait_result();
        nv       = 0;
        vcyc     = -1;
        busy_bad = 1'b0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (bus.crc_valid) begin
                if (nv == 0) begin
                    got  = bus.crc_out;
                    vcyc = cyc;
                end
                nv++;
                if (bus.busy) busy_bad = 1'b1;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic load_check_msg();
        msg_q.delete();
        for (int i = 0; i < 9; i++) msg_q.push_back(8'h31 + 8'(i));
    endtask

    initial begin
        bus.start = 1'b0; bus.abort = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = 32'd0; bus.in_last = 1'b0; bus.in_bytes = 3'd0;
        set_cfg(2'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", {31'd0, bus.in_ready}, 32'd0);
        check("reset_busy", {31'd0, bus.busy}, 32'd0);
        check("reset_crc_valid", {31'd0, bus.crc_valid}, 32'd0);
        check("reset_crc_out", bus.crc_out, 32'd0);
        rst = 1'b0;

        vecs[0] = '{2'd2, 32'h04C1_1DB7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'hCBF4_3926};
        vecs[1] = '{2'd1, 32'h0000_8005, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_FEE8};
        vecs[2] = '{2'd1, 32'h0000_8005, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1, 32'h0000_BB3D};
        vecs[3] = '{2'd1, 32'h0000_1021, 32'h0000_FFFF, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_29B1};
        vecs[4] = '{2'd0, 32'h0000_0007, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_00F4};

        // Catalogue vectors over "123456789", words driven back-to-back.
        load_check_msg();
        for (int v = 0; v < 5; v++) begin
            set_cfg(vecs[v].w, vecs[v].poly, vecs[v].init, vecs[v].xo, vecs[v].ri, vecs[v].ro);
            do_start();
            send_message(0, 1'b0);
            wait_result();
            check($sformatf("vec%0d_crc", v), got, vecs[v].exp);
            check($sformatf("vec%0d_strobes", v), 32'(nv), 32'd1);
            check($sformatf("vec%0d_busy_at_valid", v), {31'd0, busy_bad}, 32'd0);
            if (vecs[v].w != 2'd2)
                check($sformatf("vec%0d_high_zero", v), got >> ((vecs[v].w == 2'd0) ? 8 : 16), 32'd0);
            if (v == 0) begin
                check("first_accept_latency", 32'(first_acc - start_edge), 32'd1);
                check("no_bubbles", 32'(last_acc - first_acc), 32'd8);
                check("result_latency", 32'(vcyc - last_acc), 32'd2);
            end
        end

        // Abort after the second word: no strobe, crc_out keeps the CRC-8 result.
        set_cfg(2'd2, 32'h04C1_1DB7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1);
        do_start();
        push_word(32'h3433_3231, 1'b0, 3'd4, 0);
        push_word(32'h3837_3635, 1'b0, 3'd4, 0);
        bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.abort = 1'b0;
        check("abort_busy", {31'd0, bus.busy}, 32'd0);
        check("abort_in_ready", {31'd0, bus.in_ready}, 32'd0);
        wait_result();
        check("abort_no_strobe", 32'(nv), 32'd0);
        check("abort_crc_held", bus.crc_out, 32'h0000_00F4);

        // Full message after the abort.
        do_start();
        send_message(0, 1'b0);
        wait_result();
        check("after_abort_crc", got, 32'hCBF4_3926);

        // Same message with random in_valid gaps.
        do_start();
        send_message(40, 1'b0);
        wait_result();
        check("gaps_crc", got, 32'hCBF4_3926);
        check("gaps_strobes", 32'(nv), 32'd1);

        // rst while two bytes remain buffered.
        do_start();
        push_word(32'h3433_3231, 1'b0, 3'd4, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_crc_valid", {31'd0, bus.crc_valid}, 32'd0);
        check("rst_crc_out", bus.crc_out, 32'd0);
        begin
            bit act;
            act = 1'b0;
            bus.in_valid = 1'b1;
            bus.in_last  = 1'b1;
            bus.in_bytes = 3'd4;
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                if (bus.in_ready || bus.busy || bus.crc_valid) act = 1'b1;
                @(posedge clk); #1;
            end
            bus.in_valid = 1'b0;
            check("idle_in_valid_ignored", {31'd0, act}, 32'd0);
        end
        do_start();
        send_message(0, 1'b0);
        wait_result();
        check("after_rst_crc", got, 32'hCBF4_3926);

        // Zero-length message: a lone last word with in_bytes = 0.
        msg_q.delete();
        do_start();
        send_message(0, 1'b0);
        wait_result();
        check("empty_crc", got, 32'h0000_0000);
        check("empty_strobes", 32'(nv), 32'd1);
        check("empty_latency", 32'(vcyc - last_acc), 32'd1);

        // Randomized configurations and messages against the reference model.
        for (int r = 0; r < 24; r++) begin
            logic [1:0]  w;
            logic [31:0] poly, init, xo, expv;
            logic        ri, ro;
            int          len;
            bit          zt;
            w    = 2'($urandom_range(0, 3));
            poly = $urandom;
            init = $urandom;
            xo   = $urandom;
            ri   = 1'($urandom_range(0, 1));
            ro   = 1'($urandom_range(0, 1));
            len  = $urandom_range(0, 11);
            msg_q.delete();
            for (int i = 0; i < len; i++) msg_q.push_back(8'($urandom));
            zt   = ((len % 4) == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            expv = ref_crc(w, poly, init, xo, ri, ro);
            set_cfg(w, poly, init, xo, ri, ro);
            do_start();
            set_cfg(~w, $urandom, $urandom, $urandom, ~ri, ~ro);
            send_message(30, zt);
            wait_result();
            check($sformatf("rand%0d_crc", r), got, expv);
            check($sformatf("rand%0d_strobes", r), 32'(nv), 32'd1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/crc_stream_engine.md
# crc_stream_engine

Streaming, run-time configurable CRC engine that succeeds the fixed two-mode (CRC-32 / CRC-16) accelerator. It accepts a message as a stream of DATA_WIDTH-bit words over a valid/ready handshake and consumes one byte per clock. The polynomial, width (8/16/32), init value, input/output reflection and final XOR are all programmable per message, and a one-cycle result strobe marks completion. It sits between the SRAM read path and the result register, and replaces the single-word, combinational CRC path.

## Interface
- DATA_WIDTH, 32: input word width; multiple of 8, 8..64.
- NB, DATA_WIDTH/8: bytes per word (derived, not overridable).
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin message; samples cfg_* in IDLE only.
- abort  in  1  drop current message, return to IDLE, no result.
- cfg_width  in  2  0 = CRC-8, 1 = CRC-16, 2 = CRC-32, 3 = reserved (treated as 32).
- cfg_poly  in  32  polynomial, normal form, low W bits used.
- cfg_init  in  32  initial register value, low W bits used.
- cfg_xorout  in  32  final XOR, low W bits used.
- cfg_refin  in  1  reflect each input byte.
- cfg_refout  in  1  reflect the W-bit result before the XOR.
- in_valid  in  1  word valid.
- in_ready  out  1  engine can accept a word this cycle.
- in_data  in  DATA_WIDTH  byte lane 0 = in_data[7:0], processed first.
- in_last  in  1  final word of the message.
- in_bytes  in  $clog2(NB)+1  valid bytes in the last word, 0..NB; ignored when in_last = 0.
- busy  out  1  state != IDLE.
- crc_valid  out  1  one-cycle result strobe.
- crc_out  out  32  result, zero-extended above W.

## Operation
- States: IDLE, RUN, FINAL.
- IDLE
  - start = 1: latch cfg_*, set crc_reg = init, go to RUN.
  - start is ignored while busy.
- RUN
  - A word transfers on any edge where in_valid & in_ready. The word is loaded into a byte shift buffer with a count: NB, in_bytes if in_last, else NB.
  - Each cycle with count > 0, one byte is folded into crc_reg and the count decrements.
  - Byte fold:
    - b = refin ? bitrev8(byte) : byte.
    - crc_reg ^= b << (W-8).
    - 8 iterations of: shift left 1, XOR poly if the bit shifted out of position W-1 was 1.
    - Mask to W bits.
- in_ready = (state == RUN) && !last_pending && (count == 0 || count == 1). This sustains one byte per cycle across word boundaries.
- When the last word's final byte is folded, go to FINAL. A last word with in_bytes = 0 goes directly to FINAL on the next edge and folds nothing.
- FINAL
  - crc_out <= (refout ? bitrev_W(crc_reg) : crc_reg) ^ xorout (W bits), crc_valid <= 1.
  - Go to IDLE.
- crc_out holds its value until the next FINAL or rst.
- abort in RUN or FINAL: go to IDLE next edge, clear count, no crc_valid, crc_out unchanged. abort has priority over in_valid.
- in_valid while in IDLE or FINAL is ignored; in_ready = 0 in both.

## Timing
- Reset values: state IDLE; in_ready 0; busy 0; crc_valid 0; crc_out 0; count 0; crc_reg 0.
- rst mid-message discards everything, with identical effect to the reset values above.
- start at edge s: busy = 1 and in_ready = 1 from cycle s+1.
- Word of n bytes accepted at edge t: its bytes fold at edges t+1..t+n.
- For the last word, FINAL is entered at edge t+n; crc_valid is high and crc_out is valid in the cycle after edge t+n+1, exactly one cycle.
- busy drops in the same cycle crc_valid is asserted.
- Message latency from the last accept: n+1 cycles. Throughput: 1 byte/clk with no bubbles between words.
- in_data, in_last and in_bytes are sampled only on the transfer edge. Upstream must hold them while in_valid = 1 && in_ready = 0.
- cfg_* changes during RUN have no effect.

## Test plan
- CRC-32 (poly 04C11DB7, init FFFFFFFF, refin = refout = 1, xorout FFFFFFFF) over "123456789":
  - Stimulus: words 34333231, 38373635, then 00000039 with in_last = 1, in_bytes = 1, driven back-to-back.
  - Expected: crc_out = CBF43926; crc_valid exactly 1 cycle; no in_ready bubbles between words.
- Same message, CRC-16/BUYPASS (cfg_width 1, poly 8005, init 0, no reflection, xorout 0) -> FEE8. CRC-16/ARC (same, refin = refout = 1) -> BB3D.
- CRC-16/CCITT-FALSE (poly 1021, init FFFF) -> 29B1. CRC-8 (poly 07, init 0) -> F4. Verify crc_out[31:W] = 0 for both.
- Backpressure and zero-length tail:
  - Random in_valid gaps give the same result as the first test.
  - A single word with in_last = 1, in_bytes = 0 -> crc_out = refout/xorout applied to init. CRC-32: 00000000.
- abort after the second word:
  - No crc_valid; busy drops next cycle; crc_out keeps its previous value.
  - A following start plus the full message -> CBF43926.
- rst asserted while count = 2:
  - Next cycle all outputs are 0.
  - start pulses and in_valid in IDLE cause no activity until a new start.
